// File: rtl/time_counter_ext.sv
// 24-hour BCD time-of-day counter with CLK_DIV prescaler, validated load,
// 12/24-hour display conversion, alarm compare and registered event pulses.
module time_counter_ext #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [19:0] load_time,
  input  logic        mode_12h,
  input  logic        alarm_en,
  input  logic [19:0] alarm_time,
  output logic [19:0] out_time,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_carry,
  output logic        alarm_hit,
  output logic        load_err
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic [19:0]   cur;
  logic [19:0]   inc_time;
  logic [19:0]   nxt_time;
  logic          valid;
  logic          load_ok;
  logic          adv;
  logic          tick;

  // Hours are BCD, so 12..23 and the 12-hour remap can be done with BCD constants.
  function automatic logic [19:0] to_disp(input logic [19:0] t, input logic m12);
    logic [5:0] h;
    h = t[19:14];
    if (m12) begin
      if (h == 6'h00)
        h = 6'h12;
      else if (h >= 6'h13 && h <= 6'h19)
        h = h - 6'h12;
      else if (h == 6'h20 || h == 6'h21)
        h = h - 6'h18;
      else if (h >= 6'h22)
        h = h - 6'h12;
    end
    return {h, t[13:0]};
  endfunction

  always_comb begin
    inc_time = cur;
    if (cur[3:0] != 4'd9) begin
      inc_time[3:0] = cur[3:0] + 4'd1;
    end else begin
      inc_time[3:0] = '0;
      if (cur[6:4] != 3'd5) begin
        inc_time[6:4] = cur[6:4] + 3'd1;
      end else begin
        inc_time[6:4] = '0;
        if (cur[10:7] != 4'd9) begin
          inc_time[10:7] = cur[10:7] + 4'd1;
        end else begin
          inc_time[10:7] = '0;
          if (cur[13:11] != 3'd5) begin
            inc_time[13:11] = cur[13:11] + 3'd1;
          end else begin
            inc_time[13:11] = '0;
            if (cur[19:14] == 6'h23) begin
              inc_time[19:14] = '0;
            end else if (cur[17:14] == 4'd9) begin
              inc_time[17:14] = '0;
              inc_time[19:18] = cur[19:18] + 2'd1;
            end else begin
              inc_time[17:14] = cur[17:14] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    valid = (load_time[3:0] <= 4'd9) && (load_time[6:4] <= 3'd5) &&
            (load_time[10:7] <= 4'd9) && (load_time[13:11] <= 3'd5) &&
            (load_time[17:14] <= 4'd9) && (load_time[19:14] <= 6'h23);
    load_ok  = load && valid;
    adv      = en && (presc == PMAX);
    tick     = adv && !load_ok;
    nxt_time = load_ok ? load_time : (adv ? inc_time : cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      cur       <= '0;
      out_time  <= '0;
      pm        <= 1'b0;
      sec_tick  <= 1'b0;
      day_carry <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (load_ok)
        presc <= '0;
      else if (en)
        presc <= (presc == PMAX) ? '0 : presc + PW'(1);
      cur       <= nxt_time;
      out_time  <= to_disp(nxt_time, mode_12h);
      pm        <= (nxt_time[19:14] >= 6'h12);
      sec_tick  <= tick;
      day_carry <= tick && (inc_time == '0);
      alarm_hit <= tick && alarm_en && (inc_time == alarm_time);
      load_err  <= load && !valid;
    end
  end

endmodule
